// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream byte-path types for the receive pipeline.
// Entry layout, write-side FSM states and a saturating counter helper.
package axi_stream_pkg;

  localparam int AXIS_BYTE_W = 8;

  typedef struct packed {
    logic                   last;
    logic [AXIS_BYTE_W-1:0] data;
  } axis_byte_entry_t;

  typedef enum logic {
    WR_WRITE   = 1'b0,
    WR_DISCARD = 1'b1
  } drop_wr_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one clock, registered read; rd_data holds while rd_en=0.
// Latency: 1 cycle read. No backpressure; caller owns address safety.
module sdp_ram #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_fcs_drop_fifo.sv
// Store-and-forward frame FIFO: drops bad-FCS / overflowing frames; DROP_FIFO_STATS_EN adds drop counters.
// Latency: first byte of a committed frame on m_axis 2 cycles after its tlast edge (RAM read + output reg).
// Backpressure: never stalls s_axis; m_axis holds data stable while tvalid && !tready.
module axis_fcs_drop_fifo
  import axi_stream_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXIS_BYTE_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_bad_fcs,
  output logic [AXIS_BYTE_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [31:0]            drop_count,
  output logic [31:0]            ovf_count
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  drop_wr_state_e   state, state_nxt;
  logic [PW-1:0]    wr_ptr, wr_commit, rd_ptr, used;
  logic             beat, full, wr_en, do_commit, do_drop, do_ovf;
  logic             ram_vld, rd_en, load_out;
  axis_byte_entry_t wr_entry, rd_entry;

  assign s_axis_tready = rst_n;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign used          = wr_ptr - rd_ptr;
  assign full          = (used == FULL_LVL);
  assign wr_entry      = '{last: s_axis_tlast, data: s_axis_tdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WR_WRITE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WR_WRITE:   if (beat && full && !s_axis_tlast) state_nxt = WR_DISCARD;
      WR_DISCARD: if (beat && s_axis_tlast)          state_nxt = WR_WRITE;
      default:    state_nxt = WR_WRITE;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    do_ovf    = 1'b0;
    if (state == WR_WRITE && beat) begin
      if (full) begin
        do_ovf = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (s_axis_tlast) begin
          do_drop   = s_bad_fcs;
          do_commit = !s_bad_fcs;
        end
      end
    end
  end

  // Dropping rewinds to the last commit point, so an aborted frame never becomes readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      if (do_drop || do_ovf) wr_ptr <= wr_commit;
      else if (wr_en)        wr_ptr <= wr_ptr + PW'(1);
      if (do_commit)         wr_commit <= wr_ptr + PW'(1);
    end
  end

  sdp_ram #(
    .WIDTH ($bits(axis_byte_entry_t)),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr[ADDR_W-1:0]),
    .wr_data(wr_entry),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr[ADDR_W-1:0]),
    .rd_data(rd_entry)
  );

  // Two-stage read pipe: a RAM fetch is issued only when its result has somewhere to go.
  assign load_out = !m_axis_tvalid || m_axis_tready;
  assign rd_en    = (rd_ptr != wr_commit) && (!ram_vld || load_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      ram_vld <= rd_en || (ram_vld && !load_out);
      if (load_out) begin
        m_axis_tvalid <= ram_vld;
        if (ram_vld) begin
          m_axis_tdata <= rd_entry.data;
          m_axis_tlast <= rd_entry.last;
        end
      end
    end
  end

`ifdef DROP_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      ovf_count  <= '0;
    end else begin
      if (do_drop) drop_count <= sat_inc(drop_count);
      if (do_ovf)  ovf_count  <= sat_inc(ovf_count);
    end
  end
`else
  assign drop_count = '0;
  assign ovf_count  = '0;
`endif

endmodule
